// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM core's memory-side stages.
// The external SRAM controller uses the access FSM states and the SRAM geometry constants.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } sram_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int          HALF_W            = 16;

    function automatic logic phase_active(input sram_state_e st);
        return (st == LOW) || (st == HIGH);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit asynchronous SRAM
// accesses with programmable wait states, holding ready low until the word completes.
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    output logic                ready,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [HALF_W-1:0]   sram_dq_out,
    output logic                sram_dq_oe,
    input  logic [HALF_W-1:0]   sram_dq_in,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n
);

    localparam int            CW   = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);
    localparam int            IW   = SRAM_AW - 1;

    sram_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 is_wr_q, is_wr_d;
    logic [31:0]          read_data_q, read_data_d;
    logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
    logic [HALF_W-1:0]    dq_out_q, dq_out_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 ce_n_q, ce_n_d;
    logic                 oe_n_q, oe_n_d;
    logic                 we_n_q, we_n_d;

    logic                 req;
    logic [31:0]          offset;
    logic [IW-1:0]        req_idx;
    logic                 active_d;
    logic                 half_d;
    logic                 last_d;
    logic                 unused_addr_bits;

    assign req     = rd_en | wr_en;
    assign offset  = address - BASE_ADDR;
    // Out-of-range addresses simply wrap: only the low index bits reach the pins.
    assign req_idx = offset[SRAM_AW:2];
    assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        read_data_d = read_data_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    idx_d   = req_idx;
                    wdata_d = write_data;
                    is_wr_d = wr_en;
                end
            end
            LOW: begin
                if (cnt_q == LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (!is_wr_q) read_data_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!is_wr_q) read_data_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pad outputs are computed for the cycle being entered, so the flops line up with state_q.
        active_d = phase_active(state_d);
        half_d   = (state_d == HIGH);
        last_d   = (cnt_d == LAST);

        ce_n_d      = ~active_d;
        oe_n_d      = ~(active_d & ~is_wr_d);
        we_n_d      = ~(active_d & is_wr_d & ~last_d);
        dq_oe_d     = active_d & is_wr_d;
        dq_out_d    = (active_d & is_wr_d) ? (half_d ? wdata_d[31:16] : wdata_d[15:0]) : '0;
        sram_addr_d = active_d ? {idx_d, half_d} : sram_addr_q;
    end

    // NOTE: non-blocking assignments here so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    assign ready       = (state_q == IDLE) ? ~req : (state_q == DONE);
    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: two instances (WAIT_CYCLES 1 and 3), each
// with its own SRAM device model, word-level reference memory and bus monitor.
module tb_sram_controller;

    localparam logic [31:0] BASE = 32'd1024;
    localparam int          AW   = 18;

    typedef struct {
        logic        is_wr;
        logic [31:0] rdata;
        logic [17:0] a_lo;
        logic [15:0] d_lo;
        logic [15:0] d_hi;
    } exp_t;

    logic clk;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word index in SRAM, wrapped modulo the SRAM size (2^17 words).
    function automatic int unsigned widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off >> 2) % (32'd1 << (AW - 1));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : 3;

        logic        rst, wr_en, rd_en, ready;
        logic [31:0] address, write_data, read_data;
        logic [17:0] sram_addr;
        logic [15:0] dq_out, dq_in;
        logic        dq_oe, ce_n, oe_n, we_n;

        logic [15:0] dev [0:(1<<AW)-1];
        logic [31:0] ref_mem [int unsigned];
        logic [31:0] last_rd;
        exp_t        sb[$];
        bit          fin = 1'b0;

        sram_controller #(
            .SRAM_AW    (AW),
            .WAIT_CYCLES(W),
            .BASE_ADDR  (BASE)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (wr_en),
            .rd_en      (rd_en),
            .address    (address),
            .write_data (write_data),
            .read_data  (read_data),
            .ready      (ready),
            .sram_addr  (sram_addr),
            .sram_dq_out(dq_out),
            .sram_dq_oe (dq_oe),
            .sram_dq_in (dq_in),
            .sram_ce_n  (ce_n),
            .sram_oe_n  (oe_n),
            .sram_we_n  (we_n)
        );

        assign dq_in = (!ce_n && !oe_n) ? dev[sram_addr] : 16'h0000;

        function automatic logic [31:0] ref_rd(input int unsigned i);
            return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
        endfunction

        task automatic wait_done();
            bit seen = 1'b0;
            for (int n = 0; n < 40; n++) begin
                @(posedge clk);
                #1;
                if (ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("done_timeout", 32'(seen), 32'd1);
            wr_en = 1'b0;
            rd_en = 1'b0;
        endtask

        task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
            exp_t        e;
            int unsigned i;
            @(posedge clk);
            #1;
            i = widx(a);
            if (w) ref_mem[i] = d;
            else if (r) last_rd = ref_rd(i);
            e.is_wr = w;
            e.rdata = last_rd;
            e.a_lo  = 18'(i * 2);
            e.d_lo  = d[15:0];
            e.d_hi  = d[31:16];
            sb.push_back(e);
            wr_en = w;
            rd_en = r;
            address = a;
            write_data = d;
            wait_done();
        endtask

        task automatic idle(input int n);
            repeat (n) @(posedge clk);
        endtask

        // Store aborted by reset in the first cycle of its high phase: only the low half lands.
        task automatic reset_mid_store(input logic [31:0] a, input logic [31:0] d);
            int unsigned i;
            @(posedge clk);
            #1;
            i = widx(a);
            ref_mem[i] = {ref_rd(i) >> 16, d[15:0]};
            wr_en = 1'b1;
            rd_en = 1'b0;
            address = a;
            write_data = d;
            repeat (W + 2) @(posedge clk);
            #2;
            rst = 1'b0;
            #1;
            check("rst_ce_n", 32'(ce_n), 32'd1);
            check("rst_we_n", 32'(we_n), 32'd1);
            check("rst_oe_n", 32'(oe_n), 32'd1);
            check("rst_dq_oe", 32'(dq_oe), 32'd0);
            check("rst_read_data", read_data, 32'h0);
            last_rd = 32'h0;
            wr_en = 1'b0;
            #1;
            check("rst_ready", 32'(ready), 32'd1);
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            check("post_rst_ready", 32'(ready), 32'd1);
        endtask

        // Monitor: owns the SRAM device array, checks bus rules every cycle and
        // compares each completed access against the scoreboard.
        initial begin
            int          lowc = 0, wec = 0, oec = 0;
            bit          in_txn = 1'b0;
            logic [17:0] fa = '0, la = '0;
            logic [15:0] fd = '0, ld = '0;
            exp_t        e;
            for (int k = 0; k < (1 << AW); k++) dev[k] = 16'h0000;
            dev[2] = 16'h1234;
            dev[3] = 16'hABCD;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    in_txn = 1'b0;
                    lowc = 0;
                    wec = 0;
                    oec = 0;
                end else begin
                    check("we_oe_not_both_low", 32'(we_n | oe_n), 32'd1);
                    if (!oe_n) check("dq_oe_during_load", 32'(dq_oe), 32'd0);
                    if (!ce_n && !we_n && dq_oe) dev[sram_addr] = dq_out;
                    if (!we_n) begin
                        if (wec == 0) begin
                            fa = sram_addr;
                            fd = dq_out;
                        end
                        la = sram_addr;
                        ld = dq_out;
                        wec++;
                    end
                    if (!oe_n) oec++;
                    if (!in_txn && (wr_en || rd_en)) check("ready_on_request", 32'(ready), 32'd0);
                    if (!ready) begin
                        in_txn = 1'b1;
                        lowc++;
                    end else if (in_txn) begin
                        if (sb.size() == 0) begin
                            check("scoreboard_empty", 32'd1, 32'd0);
                        end else begin
                            e = sb.pop_front();
                            check("ready_low_cycles", 32'(lowc), 32'(2 * W + 3));
                            check("we_low_cycles", 32'(wec), e.is_wr ? 32'(2 * W) : 32'd0);
                            check("oe_low_cycles", 32'(oec), e.is_wr ? 32'd0 : 32'(2 * W + 2));
                            check("read_data", read_data, e.rdata);
                            if (e.is_wr) begin
                                check("wr_addr_lo", 32'(fa), 32'(e.a_lo));
                                check("wr_data_lo", 32'(fd), 32'(e.d_lo));
                                check("wr_addr_hi", 32'(la), 32'(e.a_lo | 18'd1));
                                check("wr_data_hi", 32'(ld), 32'(e.d_hi));
                            end
                        end
                        in_txn = 1'b0;
                        lowc = 0;
                        wec = 0;
                        oec = 0;
                    end
                end
            end
        end

        initial begin
            logic [31:0] a, d;
            int          op, k, sel;
            rst = 1'b0;
            wr_en = 1'b0;
            rd_en = 1'b0;
            address = '0;
            write_data = '0;
            last_rd = 32'h0;
            ref_mem[1] = 32'hABCD1234;
            repeat (3) @(posedge clk);
            #1;
            check("reset_ready", 32'(ready), 32'd1);
            check("reset_ce_n", 32'(ce_n), 32'd1);
            check("reset_oe_n", 32'(oe_n), 32'd1);
            check("reset_we_n", 32'(we_n), 32'd1);
            check("reset_dq_oe", 32'(dq_oe), 32'd0);
            check("reset_dq_out", 32'(dq_out), 32'd0);
            check("reset_sram_addr", 32'(sram_addr), 32'd0);
            check("reset_read_data", read_data, 32'h0);
            @(posedge clk);
            #2;
            rst = 1'b1;

            issue(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
            issue(1'b0, 1'b1, 32'd1028, 32'h0);
            issue(1'b1, 1'b0, 32'd1032, 32'h600DF00D);
            issue(1'b0, 1'b1, 32'd1032, 32'h0);
            issue(1'b1, 1'b1, 32'd1036, 32'h0000FFFF);
            issue(1'b0, 1'b1, 32'd1036, 32'h0);
            reset_mid_store(32'd1024, 32'h55AA33CC);
            issue(1'b0, 1'b1, 32'd1024, 32'h0);

            for (int t = 0; t < 40; t++) begin
                op  = $urandom_range(0, 3);
                k   = $urandom_range(0, 15);
                sel = $urandom_range(0, 3);
                if (sel == 0) a = BASE + 32'(4 * k) + (32'd1 << 19);
                else if (sel == 1) a = BASE - 32'(4 * (k + 1));
                else a = BASE + 32'(4 * k);
                d = $urandom;
                case (op)
                    0:       issue(1'b1, 1'b0, a, d);
                    2:       issue(1'b1, 1'b1, a, d);
                    default: issue(1'b0, 1'b1, a, d);
                endcase
                idle($urandom_range(0, 2));
            end
            idle(2);
            fin = 1'b1;
        end
    end

    initial begin
        bit all_done = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (g_dut[0].fin && g_dut[1].fin) begin
                all_done = 1'b1;
                break;
            end
        end
        check("all_sequences_done", 32'(all_done), 32'd1);
        check("scoreboard_drained_w1", 32'(g_dut[0].sb.size()), 32'd0);
        check("scoreboard_drained_w3", 32'(g_dut[1].sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-side stage that sits directly downstream of the pipelined ARM core's MEM stage and replaces the on-chip data memory with an external 16-bit asynchronous SRAM. Each 32-bit load or store from MEM is split into two half-word SRAM accesses with programmable wait states. `ready` is held low for the whole access so the core freezes its pipeline until the data word is complete.

## Interface
Parameters:
- `SRAM_AW`, 18: SRAM address width, in half-words.
- `WAIT_CYCLES`, 1: extra cycles per half-word phase; must be ≥ 1.
- `BASE_ADDR`, 1024: CPU byte address that maps to SRAM word 0.

Ports:
- `clk`  in  1: core clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `wr_en`  in  1: MEM-stage store request.
- `rd_en`  in  1: MEM-stage load request.
- `address`  in  32: CPU byte address; word aligned.
- `write_data`  in  32: store data.
- `read_data`  out  32: load result, registered.
- `ready`  out  1: low means freeze the pipeline.
- `sram_addr`  out  SRAM_AW: half-word address.
- `sram_dq_out`  out  16: write data driven to the pad.
- `sram_dq_oe`  out  1: pad output enable, active-high.
- `sram_dq_in`  in  16: read data from the pad.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each: SRAM strobes, active-low.

## Operation
- Address map:
  - word index = (`address` − `BASE_ADDR`) >> 2.
  - `sram_addr` = {word index[SRAM_AW−2:0], half}.
  - The low half (half = 0) is accessed first.
  - Addresses outside the SRAM range wrap modulo the SRAM size. No fault is raised.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE → LOW when `rd_en | wr_en`. On that edge the block latches `address`, `write_data` and the op type.
  - LOW → HIGH after WAIT_CYCLES+1 cycles.
  - HIGH → DONE after WAIT_CYCLES+1 cycles.
  - DONE → IDLE unconditionally.
- Phase counter: 0..WAIT_CYCLES, cleared on every phase entry.
- `ready` is combinational:
  - In IDLE: `ready` = ~(`rd_en` | `wr_en`).
  - In LOW and HIGH: `ready` = 0.
  - In DONE: `ready` = 1.
- Store behaviour:
  - `sram_dq_oe` = 1 throughout LOW and HIGH.
  - `sram_dq_out` = write_data[15:0] in LOW and write_data[31:16] in HIGH.
  - `sram_we_n` = 0 on every cycle of a phase except its last, so data is held past the rising edge of WE.
- Load behaviour:
  - `sram_oe_n` = 0 throughout LOW and HIGH.
  - `sram_dq_in` is captured on the last cycle of LOW into read_data[15:0], and on the last cycle of HIGH into read_data[31:16].
- `sram_ce_n` = 0 in LOW and HIGH only.
- `read_data` holds its last loaded value across stores and idle cycles.
- Simultaneous `rd_en` and `wr_en`: the store wins and `read_data` is unchanged.
- Request inputs are ignored in LOW, HIGH and DONE, because the core holds them stable while frozen.
- Strobe and output-enable rule: `sram_we_n` and `sram_oe_n` are never both low; `sram_dq_oe` is never high during a load.

## Timing
- Reset values:
  - state = IDLE; counter = 0; `read_data` = 0.
  - `sram_ce_n` = `sram_oe_n` = `sram_we_n` = 1.
  - `sram_dq_oe` = 0; `sram_dq_out` = 0; `sram_addr` = 0.
  - `ready` = 1 when no request is present.
- Reset asserted mid-access aborts immediately and asynchronously: all strobes go high and the state returns to IDLE. A partially written word is left as is.
- Latency: a request seen in IDLE in cycle 0 gives `ready` = 0 for cycles 0..2·WAIT_CYCLES+2, and `ready` = 1 in cycle 2·WAIT_CYCLES+3.
  - With WAIT_CYCLES = 1, the pipeline is frozen for 5 cycles and `ready` rises in cycle 5.
- `read_data` is valid from the DONE cycle onward; the core's MEM/WB register samples it at the end of DONE.
- Back-to-back requests: a new request is accepted in the cycle after DONE. The gap costs no extra bubble beyond the IDLE cycle.
- Non-memory instructions pass in IDLE with zero stall.

## Structure
- Shared package `arm_mem_pkg`:
  - state enum {IDLE, LOW, HIGH, DONE}.
  - default `BASE_ADDR` constant.
  - SRAM half-word width constant (16).
- No sub-module. The FSM, phase counter, address translation and data capture live in one module, about 150–200 lines.
- The pad tristate (`sram_dq_oe`) is resolved at the top level, never inside this block.

## Test plan
- Store 0xDEADBEEF to address 1024 with WAIT_CYCLES = 1:
  - `sram_addr` = 0 with dq 0xBEEF, then `sram_addr` = 1 with dq 0xDEAD.
  - `sram_we_n` is low for 1 cycle per phase.
  - `ready` is low for 5 cycles.
- Load from address 1028 with an SRAM model holding 0x1234 at half-word 2 and 0xABCD at half-word 3:
  - `read_data` = 0xABCD1234 in the DONE cycle.
  - `sram_oe_n` is low for 4 cycles.
- Back-to-back store then load to the same address returns the stored word. Total freeze is 10 cycles plus 1 IDLE cycle.
- `rd_en` = `wr_en` = 1 with write_data 0x0000FFFF:
  - SRAM is written with 0xFFFF then 0x0000.
  - `read_data` keeps its prior value.
- `rst` pulsed low during HIGH of a store:
  - Strobes go high the same cycle and state = IDLE.
  - `ready` = 1 once requests are removed.
  - The next access completes normally.
- Sweep WAIT_CYCLES ∈ {1, 3}:
  - `ready` rises exactly at cycle 2·WAIT_CYCLES+3.
  - `sram_we_n` and `sram_oe_n` are never both low.
